// File: rtl/button_events.sv
// Button event detector: turns a debounced, clk-synchronous button level
// into press / release / short-click / long-press / auto-repeat pulses plus a
// held level. Every output comes straight from a flop.
//
// "release" and "repeat" are SystemVerilog keywords, so those two outputs are
// named release_pulse and repeat_pulse.
//
// Handshake: none. level and enable are sampled on every rising clk edge.
// Each pulse output is high for exactly one cycle per event.
module button_events #(
    parameter int LONG_CYCLES   = 5000000,
    parameter int REPEAT_CYCLES = 1250000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic enable,
    output logic press,
    output logic release_pulse,
    output logic short_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    // Counter values at which the long threshold / repeat interval is reached.
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    // Next state, counter and registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lvl_d     = level;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        if (!enable) begin
            // Forced idle: any tracked press is dropped silently.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Only a fresh rising edge starts a press; lvl_q tracks
                    // level even while disabled or in reset recovery.
                    if (level && !lvl_q) begin
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                S_PRESSED: begin
                    // Release is checked first so it wins over the threshold.
                    if (!level) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        short_d   = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = S_LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_LONG: begin
                    if (!level) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (REPEAT_EN) begin
                        if (cnt_q == REPEAT_LAST) begin
                            cnt_d    = '0;
                            repeat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = (state_d == S_PRESSED) || (state_d == S_LONG);
    end

    // State and output registers; lvl_q resets high so a button held through
    // reset is not mistaken for a new press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lvl_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign short_click   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule
